// File: rtl/nand_logic_sweeper_if.sv
// Control/status bundle between a sweep controller and the NAND logic sweeper.
interface nand_logic_sweeper_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             start;
    logic [2:0]       mode;
    logic             fault_en;
    logic [WIDTH-1:0] a_drv;
    logic [WIDTH-1:0] b_drv;
    logic [WIDTH-1:0] q_nand;
    logic             busy;
    logic             done;
    logic             pass;
    logic             mode_err;
    logic [ERR_W-1:0] err_count;

    modport master (
        output start, mode, fault_en,
        input  a_drv, b_drv, q_nand, busy, done, pass, mode_err, err_count
    );

    modport slave (
        input  start, mode, fault_en,
        output a_drv, b_drv, q_nand, busy, done, pass, mode_err, err_count
    );
endinterface

// File: rtl/nand_logic_sweeper.sv
// Self-sweeping checker: NAND-only gate network vs behavioural reference, all 2^(2*WIDTH) pairs.
// Latency: done rises N+1 clocks after the accepted start edge; illegal mode reports after 1 clock.
// Backpressure: none; start is ignored while busy and only sampled in IDLE/DONE.

module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);
    nand g_nand (y, a, b);
endmodule

module nand_logic_sweeper #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
) (
    input logic                clk,
    input logic                rst,
    nand_logic_sweeper_if.slave sw
);
    localparam int CW = 2 * WIDTH;
    localparam logic [CW-1:0]    LAST_VEC = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] q_nand_r;
    logic [WIDTH-1:0] q_ref_r;
    logic             cap_vld;
    logic             busy_r;
    logic             done_r;
    logic             pass_r;
    logic             mode_err_r;
    logic [ERR_W-1:0] err_count_r;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    assign a = cnt[WIDTH-1:0];
    assign b = cnt[CW-1:WIDTH];

    // Gate network: every function below is built from nand2 cells only.
    logic [WIDTH-1:0] f_nand, f_and, f_or, f_nor, f_xor, f_xnor;
    logic [WIDTH-1:0] n_a, n_b, x_t1, x_t2;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nand2 u_nand (.a(a[i]),      .b(b[i]),      .y(f_nand[i]));
        nand2 u_and  (.a(f_nand[i]), .b(f_nand[i]), .y(f_and[i]));
        nand2 u_na   (.a(a[i]),      .b(a[i]),      .y(n_a[i]));
        nand2 u_nb   (.a(b[i]),      .b(b[i]),      .y(n_b[i]));
        nand2 u_or   (.a(n_a[i]),    .b(n_b[i]),    .y(f_or[i]));
        nand2 u_nor  (.a(f_or[i]),   .b(f_or[i]),   .y(f_nor[i]));
        nand2 u_xt1  (.a(a[i]),      .b(f_nand[i]), .y(x_t1[i]));
        nand2 u_xt2  (.a(b[i]),      .b(f_nand[i]), .y(x_t2[i]));
        nand2 u_xor  (.a(x_t1[i]),   .b(x_t2[i]),   .y(f_xor[i]));
        nand2 u_xnor (.a(f_xor[i]),  .b(f_xor[i]),  .y(f_xnor[i]));
    end

    logic [WIDTH-1:0] net_sel;
    always_comb begin
        net_sel = '0;
        case (mode_q)
            3'd0:    net_sel = f_nor;
            3'd1:    net_sel = f_and;
            3'd2:    net_sel = f_or;
            3'd3:    net_sel = f_xor;
            3'd4:    net_sel = f_xnor;
            3'd5:    net_sel = f_nand;
            default: net_sel = '0;
        endcase
    end

    // Fault injection: bit 0 XOR fault_en, still NAND-only.
    logic fi_u, fi_v, fi_w, fi_bit;
    nand2 u_fi_u (.a(net_sel[0]),  .b(sw.fault_en), .y(fi_u));
    nand2 u_fi_v (.a(net_sel[0]),  .b(fi_u),        .y(fi_v));
    nand2 u_fi_w (.a(sw.fault_en), .b(fi_u),        .y(fi_w));
    nand2 u_fi_y (.a(fi_v),        .b(fi_w),        .y(fi_bit));

    logic [WIDTH-1:0] q_net;
    always_comb begin
        q_net    = net_sel;
        q_net[0] = fi_bit;
    end

    logic [WIDTH-1:0] q_ref;
    always_comb begin
        q_ref = '0;
        case (mode_q)
            3'd0:    q_ref = ~(a | b);
            3'd1:    q_ref = a & b;
            3'd2:    q_ref = a | b;
            3'd3:    q_ref = a ^ b;
            3'd4:    q_ref = ~(a ^ b);
            3'd5:    q_ref = ~(a & b);
            default: q_ref = '0;
        endcase
    end

    logic mismatch;
    assign mismatch = cap_vld && (q_nand_r != q_ref_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            mode_q      <= 3'd0;
            q_nand_r    <= '0;
            q_ref_r     <= '0;
            cap_vld     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            mode_err_r  <= 1'b0;
            err_count_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (sw.start) begin
                        cnt         <= '0;
                        err_count_r <= '0;
                        cap_vld     <= 1'b0;
                        pass_r      <= 1'b0;
                        if (sw.mode > 3'd5) begin
                            state      <= DONE;
                            done_r     <= 1'b1;
                            mode_err_r <= 1'b1;
                            busy_r     <= 1'b0;
                        end else begin
                            state      <= RUN;
                            mode_q     <= sw.mode;
                            done_r     <= 1'b0;
                            mode_err_r <= 1'b0;
                            busy_r     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_nand_r <= q_net;
                    q_ref_r  <= q_ref;
                    cap_vld  <= 1'b1;
                    cnt      <= cnt + CW'(1);
                    if (mismatch && err_count_r != ERR_MAX)
                        err_count_r <= err_count_r + ERR_W'(1);
                    if (cnt == LAST_VEC)
                        state <= FLUSH;
                end
                FLUSH: begin
                    // Last captured vector is compared here, so pass accounts for it directly.
                    if (mismatch && err_count_r != ERR_MAX)
                        err_count_r <= err_count_r + ERR_W'(1);
                    pass_r  <= (err_count_r == '0) && !mismatch;
                    cap_vld <= 1'b0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state   <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sw.a_drv     = a;
    assign sw.b_drv     = b;
    assign sw.q_nand    = q_net;
    assign sw.busy      = busy_r;
    assign sw.done      = done_r;
    assign sw.pass      = pass_r;
    assign sw.mode_err  = mode_err_r;
    assign sw.err_count = err_count_r;
endmodule
